// File: rtl/addsub_accum_pkg.sv
// ============================================================================
// Module : addsub_accum_pkg
// Brief  : Shared mode encoding and default widths for the add/sub/accum pipe.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package addsub_accum_pkg;

   typedef enum logic [1:0] {
      MODE_ADD = 2'b00,
      MODE_SUB = 2'b01,
      MODE_ACC = 2'b10,
      MODE_CLR = 2'b11
   } mode_t;

   localparam int DEF_WIDTH     = 4;
   localparam int DEF_ACC_WIDTH = 8;
   localparam int DEF_CNT_WIDTH = 4;

endpackage

`default_nettype wire

// File: rtl/addsub_sat_unit.sv
// ============================================================================
// Module : addsub_sat_unit
// Brief  : Combinational add/subtract with carry/borrow and unsigned clamp.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module addsub_sat_unit
   import addsub_accum_pkg::*;
#(
   parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
   input  logic [ACC_WIDTH-1:0] x,
   input  logic [ACC_WIDTH-1:0] y,
   input  mode_t                mode,
   input  logic                 sat_en,
   output logic [ACC_WIDTH-1:0] value,
   output logic                 carry
);

   logic [ACC_WIDTH:0] w_t;

   // One extra bit holds the carry-out for add or the borrow for subtract.
   always_comb begin
      w_t   = '0;
      value = '0;
      carry = 1'b0;
      unique case (mode)
         MODE_ADD,
         MODE_ACC: w_t = {1'b0, x} + {1'b0, y};
         MODE_SUB: w_t = {1'b0, x} - {1'b0, y};
         default:  w_t = '0;
      endcase
      carry = w_t[ACC_WIDTH];
      value = w_t[ACC_WIDTH-1:0];
      if (sat_en && carry) begin
         value = (mode == MODE_SUB) ? '0 : '1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/addsub_accum_pipe.sv
// ============================================================================
// Module : addsub_accum_pipe
// Brief  : Two-stage add/sub/accumulate pipe with valid/ready on both sides.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module addsub_accum_pipe
   import addsub_accum_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int ACC_WIDTH = DEF_ACC_WIDTH,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     op_a,
   input  logic [WIDTH-1:0]     op_b,
   input  mode_t                mode,
   input  logic                 sat_en,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] result,
   output logic                 carry,
   output logic                 overflow,
   output logic [CNT_WIDTH-1:0] txn_cnt
);

   logic                 r_s1_valid;
   logic [WIDTH-1:0]     r_s1_a;
   logic [WIDTH-1:0]     r_s1_b;
   mode_t                r_s1_mode;
   logic                 r_s1_sat;

   logic                 r_s2_valid;
   logic [ACC_WIDTH-1:0] r_result;
   logic                 r_carry;
   logic                 r_overflow;

   logic [ACC_WIDTH-1:0] r_acc;
   logic [CNT_WIDTH-1:0] r_txn_cnt;

   logic                 w_s2_open;
   logic                 w_s1_adv;
   logic                 w_accept;
   logic [ACC_WIDTH-1:0] w_a_ext;
   logic [ACC_WIDTH-1:0] w_b_ext;
   logic [ACC_WIDTH-1:0] w_x;
   logic [ACC_WIDTH-1:0] w_y;
   logic [ACC_WIDTH-1:0] w_value;
   logic                 w_carry;

   assign w_s2_open = !r_s2_valid || out_ready;
   assign w_s1_adv  = r_s1_valid && w_s2_open;
   assign in_ready  = !r_s1_valid || w_s1_adv;
   assign w_accept  = in_valid && in_ready;

   // A+B cannot overflow ACC_WIDTH, so ACC folds into a single two-input add.
   assign w_a_ext = ACC_WIDTH'(r_s1_a);
   assign w_b_ext = ACC_WIDTH'(r_s1_b);
   assign w_x     = (r_s1_mode == MODE_ACC) ? r_acc : w_a_ext;
   assign w_y     = (r_s1_mode == MODE_ACC) ? (w_a_ext + w_b_ext) : w_b_ext;

   addsub_sat_unit #(
      .ACC_WIDTH (ACC_WIDTH)
   ) u_sat_unit (
      .x      (w_x),
      .y      (w_y),
      .mode   (r_s1_mode),
      .sat_en (r_s1_sat),
      .value  (w_value),
      .carry  (w_carry)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_mode  <= MODE_ADD;
         r_s1_sat   <= 1'b0;
      end else if (in_ready) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_a    <= op_a;
            r_s1_b    <= op_b;
            r_s1_mode <= mode;
            r_s1_sat  <= sat_en;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s2_valid <= 1'b0;
         r_result   <= '0;
         r_carry    <= 1'b0;
         r_overflow <= 1'b0;
      end else if (w_s2_open) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_result   <= w_value;
            r_carry    <= w_carry;
            r_overflow <= w_carry && !r_s1_sat;
         end
      end
   end

   // Accumulator moves in lockstep with S1->S2 so chained ACCs see fresh data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc <= '0;
      end else if (w_s1_adv) begin
         if (r_s1_mode == MODE_ACC) begin
            r_acc <= w_value;
         end else if (r_s1_mode == MODE_CLR) begin
            r_acc <= '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_txn_cnt <= '0;
      end else if (w_accept) begin
         r_txn_cnt <= r_txn_cnt + 1'b1;
      end
   end

   assign out_valid = r_s2_valid;
   assign result    = r_result;
   assign carry     = r_carry;
   assign overflow  = r_overflow;
   assign txn_cnt   = r_txn_cnt;

endmodule

`default_nettype wire

// File: tb/tb_addsub_accum_pipe.sv
// ============================================================================
// Module : tb_addsub_accum_pipe
// Brief  : Self-checking bench for addsub_accum_pipe against a queue-based model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_addsub_accum_pipe;
   import addsub_accum_pkg::*;

   localparam int W  = 4;
   localparam int AW = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   mode_t         mode;
   logic          sat_en;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] result;
   logic          carry;
   logic          overflow;
   logic [CW-1:0] txn_cnt;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [AW-1:0] r;
      logic          c;
      logic          o;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          log_q[$];
   int            model_acc;
   int            model_cnt;
   int            accepts;
   logic          prev_stall;
   logic [AW-1:0] prev_res;
   logic          prev_c;
   logic          prev_o;

   always #5 clk = ~clk;

   addsub_accum_pipe #(
      .WIDTH     (W),
      .ACC_WIDTH (AW),
      .CNT_WIDTH (CW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .mode      (mode),
      .sat_en    (sat_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry     (carry),
      .overflow  (overflow),
      .txn_cnt   (txn_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Reference: true integer result, then clamp or wrap into AW bits.
   function automatic exp_t model(input int a, input int b, input mode_t m, input logic s);
      int   t;
      int   maxv;
      exp_t e;
      maxv = (1 << AW) - 1;
      case (m)
         MODE_ADD: t = a + b;
         MODE_SUB: t = a - b;
         MODE_ACC: t = model_acc + a + b;
         default:  t = 0;
      endcase
      e.c = (t > maxv) || (t < 0);
      if (e.c && s) e.r = (t < 0) ? 8'h00 : 8'hFF;
      else          e.r = AW'(t & maxv);
      e.o = e.c && !s;
      if (m == MODE_ACC)      model_acc = int'(e.r);
      else if (m == MODE_CLR) model_acc = 0;
      return e;
   endfunction

   task automatic set_in(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input mode_t m, input logic s);
      in_valid = v;
      op_a     = a;
      op_b     = b;
      mode     = m;
      sat_en   = s;
   endtask

   task automatic tick();
      exp_t e;
      exp_t o;
      #1;
      if (prev_stall) begin
         chk("hold_valid",  32'(out_valid), 1);
         chk("hold_result", 32'(result), 32'(prev_res));
         chk("hold_flags",  32'({carry, overflow}), 32'({prev_c, prev_o}));
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("spurious_out", 32'(out_valid), 0);
         end else begin
            e = exp_q.pop_front();
            chk("result",   32'(result),   32'(e.r));
            chk("carry",    32'(carry),    32'(e.c));
            chk("overflow", 32'(overflow), 32'(e.o));
            o.r = result; o.c = carry; o.o = overflow;
            log_q.push_back(o);
         end
      end
      if (in_valid && in_ready) begin
         exp_q.push_back(model(int'(op_a), int'(op_b), mode, sat_en));
         model_cnt++;
         accepts++;
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = result;
      prev_c     = carry;
      prev_o     = overflow;
      @(posedge clk);
      @(negedge clk);
      chk("txn_cnt", 32'(txn_cnt), 32'(model_cnt % (1 << CW)));
   endtask

   task automatic drain();
      int n;
      n         = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      chk("drain_timeout", 32'(exp_q.size()), 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_result",    32'(result),    0);
      chk("rst_flags",     32'({carry, overflow}), 0);
      chk("rst_txn_cnt",   32'(txn_cnt),   0);
      @(posedge clk);
      @(negedge clk);
      reset      = 1'b0;
      exp_q.delete();
      model_acc  = 0;
      model_cnt  = 0;
      prev_stall = 1'b0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 1);
      @(negedge clk);
   endtask

   initial begin
      int a0;
      reset     = 1'b0;
      out_ready = 1'b1;
      set_in(1'b0, '0, '0, MODE_ADD, 1'b0);
      model_acc  = 0;
      model_cnt  = 0;
      accepts    = 0;
      prev_stall = 1'b0;
      @(negedge clk);
      do_reset();

      // ADD F+F: visible after the second edge following acceptance
      set_in(1'b1, 4'hF, 4'hF, MODE_ADD, 1'b0);
      tick();
      chk("lat_edge1", 32'(out_valid), 0);
      in_valid = 1'b0;
      tick();
      chk("lat_edge2", 32'(out_valid), 1);
      log_q.delete();
      tick();
      chk("add_ff_res", 32'(log_q[0].r), 32'h1E);
      chk("add_ff_c",   32'(log_q[0].c), 0);

      // SUB 3-5, wrap then clamp
      log_q.delete();
      set_in(1'b1, 4'h3, 4'h5, MODE_SUB, 1'b0);
      tick();
      set_in(1'b1, 4'h3, 4'h5, MODE_SUB, 1'b1);
      tick();
      drain();
      chk("sub_wrap_res", 32'(log_q[0]), 32'({8'hFE, 1'b1, 1'b1}));
      chk("sub_sat_res",  32'(log_q[1]), 32'({8'h00, 1'b1, 1'b0}));

      // CLR + 20 back-to-back ACC F+F, wrap then saturate
      for (int s = 0; s < 2; s++) begin
         log_q.delete();
         set_in(1'b1, 4'h0, 4'h0, MODE_CLR, 1'b0);
         tick();
         for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 4'hF, 4'hF, MODE_ACC, s[0]);
            tick();
         end
         drain();
         chk("acc_1st", 32'(log_q[1].r), 32'h1E);
         chk("acc_2nd", 32'(log_q[2].r), 32'h3C);
         if (s == 0) chk("acc9_wrap", 32'(log_q[9]), 32'({8'h0E, 1'b1, 1'b1}));
         else        chk("acc9_sat",  32'(log_q[9]), 32'({8'hFF, 1'b1, 1'b0}));
         if (s == 1) chk("acc20_sat", 32'(log_q[20]), 32'({8'hFF, 1'b1, 1'b0}));
      end
      log_q.delete();
      set_in(1'b1, 4'h0, 4'h0, MODE_CLR, 1'b0);
      tick();
      set_in(1'b1, 4'h1, 4'h1, MODE_ACC, 1'b0);
      tick();
      drain();
      chk("clr_res",   32'(log_q[0].r), 0);
      chk("after_clr", 32'(log_q[1].r), 32'h02);

      // Back-pressure: only two operands fit while the output is blocked
      out_ready = 1'b0;
      a0 = accepts;
      for (int i = 0; i < 5; i++) begin
         set_in(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                mode_t'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         tick();
      end
      chk("stall_accepts", 32'(accepts - a0), 2);
      #1;
      chk("stall_in_ready", 32'(in_ready), 0);
      @(negedge clk);
      drain();

      // Randomised traffic with random back-pressure
      for (int i = 0; i < 400; i++) begin
         set_in(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), mode_t'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
         out_ready = 1'($urandom_range(0, 9) < 7);
         tick();
      end
      drain();

      // Reset with both stages occupied, then accumulator must start from zero
      set_in(1'b1, 4'h7, 4'h9, MODE_ACC, 1'b0);
      out_ready = 1'b0;
      tick();
      tick();
      tick();
      in_valid = 1'b0;
      do_reset();
      out_ready = 1'b1;
      log_q.delete();
      set_in(1'b1, 4'h1, 4'h2, MODE_ACC, 1'b0);
      tick();
      drain();
      chk("acc_after_rst", 32'(log_q[0].r), 32'h03);

      // Counter wrap after 17 accepts
      do_reset();
      for (int i = 0; i < 17; i++) begin
         set_in(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                MODE_ADD, 1'b0);
         tick();
      end
      in_valid = 1'b0;
      chk("cnt_wrap", 32'(txn_cnt), 1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
